// File: rtl/memory_arb_pkg.sv
// rtl/memory_arb_pkg.sv - shared owner encoding, read latency and read-tag type for memory_arb
package memory_arb_pkg;

   localparam logic OWN_A  = 1'b0;
   localparam logic OWN_B  = 1'b1;
   localparam int   RD_LAT = 3;

   // One entry per in-flight read: travels alongside the memory read pipeline
   typedef struct packed {
      logic valid;
      logic owner;
   } rd_tag_t;

endpackage

// File: rtl/memory_arb_rr2.sv
// rtl/memory_arb_rr2.sv - arb_rr2: 2-way round-robin arbiter with registered priority pointer
module arb_rr2
   import memory_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (ptr == OWN_B) ? 2'b10 : 2'b01;
      end
   end

   // Pointer flips to the loser after every grant, holds when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= OWN_A;
      end else if (gnt[0]) begin
         ptr <= OWN_B;
      end else if (gnt[1]) begin
         ptr <= OWN_A;
      end
   end

endmodule

// File: rtl/memory_arb.sv
// rtl/memory_arb.sv - two-requester arbiter/sequencer for a 1W/1R memory; MEMORY_ARB_FWD_EN enables same-cycle write forwarding
module memory_arb
   import memory_arb_pkg::*;
#(
   parameter int AW  = 14,
   parameter int DW  = 32,
   parameter int WED = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [WED-1:0] a_wr_en,
   input  logic [AW-1:0]  a_wr_addr,
   input  logic [DW-1:0]  a_wr_data,
   output logic           a_wr_wait,
   input  logic           a_rd_en,
   input  logic [AW-1:0]  a_rd_addr,
   output logic           a_rd_wait,
   output logic           a_rd_valid,
   output logic [DW-1:0]  a_rd_data,
   input  logic [WED-1:0] b_wr_en,
   input  logic [AW-1:0]  b_wr_addr,
   input  logic [DW-1:0]  b_wr_data,
   output logic           b_wr_wait,
   input  logic           b_rd_en,
   input  logic [AW-1:0]  b_rd_addr,
   output logic           b_rd_wait,
   output logic           b_rd_valid,
   output logic [DW-1:0]  b_rd_data,
   output logic [WED-1:0] mem_wr_en,
   output logic [AW-1:0]  mem_wr_addr,
   output logic [DW-1:0]  mem_wr_data,
   output logic           mem_rd_en,
   output logic [AW-1:0]  mem_rd_addr,
   input  logic [DW-1:0]  mem_rd_data
);

   logic [1:0]    wr_req, wr_gnt;
   logic [1:0]    rd_req, rd_gnt;
   rd_tag_t       tag_q [RD_LAT-1];
   rd_tag_t       tag_out;
   logic [DW-1:0] rd_word;

   assign wr_req = {|b_wr_en, |a_wr_en};
   assign rd_req = {b_rd_en, a_rd_en};

   arb_rr2 u_wr_arb (.clk(clk), .reset(reset), .req(wr_req), .gnt(wr_gnt));
   arb_rr2 u_rd_arb (.clk(clk), .reset(reset), .req(rd_req), .gnt(rd_gnt));

   assign a_wr_wait = wr_req[0] & ~wr_gnt[0];
   assign b_wr_wait = wr_req[1] & ~wr_gnt[1];
   assign a_rd_wait = rd_req[0] & ~rd_gnt[0];
   assign b_rd_wait = rd_req[1] & ~rd_gnt[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wr_en   <= '0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
      end else begin
         mem_wr_en <= '0;
         if (wr_gnt[0]) begin
            mem_wr_en   <= a_wr_en;
            mem_wr_addr <= a_wr_addr;
            mem_wr_data <= a_wr_data;
         end else if (wr_gnt[1]) begin
            mem_wr_en   <= b_wr_en;
            mem_wr_addr <= b_wr_addr;
            mem_wr_data <= b_wr_data;
         end
      end
   end

   // mem_rd_en drops on idle cycles so the memory keeps its last read word
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
      end else begin
         mem_rd_en <= |rd_gnt;
         if (rd_gnt[0]) begin
            mem_rd_addr <= a_rd_addr;
         end else if (rd_gnt[1]) begin
            mem_rd_addr <= b_rd_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT-1; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{valid: |rd_gnt, owner: (rd_gnt[1] ? OWN_B : OWN_A)};
         for (int i = 1; i < RD_LAT-1; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_out = tag_q[RD_LAT-2];

`ifdef MEMORY_ARB_FWD_EN
   logic [WED-1:0] fwd_be;
   logic [DW-1:0]  fwd_data;

   // Capture the colliding write alongside the read so its bytes override the stale word
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_be   <= '0;
         fwd_data <= '0;
      end else begin
         fwd_be   <= (mem_rd_en && (mem_rd_addr == mem_wr_addr)) ? mem_wr_en : '0;
         fwd_data <= mem_wr_data;
      end
   end

   always_comb begin
      rd_word = mem_rd_data;
      for (int i = 0; i < WED; i++) begin
         if (fwd_be[i]) begin
            rd_word[8*i +: 8] = fwd_data[8*i +: 8];
         end
      end
   end
`else
   assign rd_word = mem_rd_data;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         a_rd_valid <= 1'b0;
         b_rd_valid <= 1'b0;
         a_rd_data  <= '0;
         b_rd_data  <= '0;
      end else begin
         a_rd_valid <= tag_out.valid && (tag_out.owner == OWN_A);
         b_rd_valid <= tag_out.valid && (tag_out.owner == OWN_B);
         if (tag_out.valid && (tag_out.owner == OWN_A)) begin
            a_rd_data <= rd_word;
         end
         if (tag_out.valid && (tag_out.owner == OWN_B)) begin
            b_rd_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_memory_arb.sv
// tb/tb_memory_arb.sv - directed vector bench for memory_arb with a registered-read memory model
module tb_memory_arb;
   import memory_arb_pkg::*;

   localparam int AW  = 14;
   localparam int DW  = 32;
   localparam int WED = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [WED-1:0] a_wr_en, b_wr_en;
   logic [AW-1:0]  a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
   logic [DW-1:0]  a_wr_data, b_wr_data;
   logic           a_rd_en, b_rd_en;
   logic           a_wr_wait, b_wr_wait, a_rd_wait, b_rd_wait;
   logic           a_rd_valid, b_rd_valid;
   logic [DW-1:0]  a_rd_data, b_rd_data;
   logic [WED-1:0] mem_wr_en;
   logic [AW-1:0]  mem_wr_addr, mem_rd_addr;
   logic [DW-1:0]  mem_wr_data, mem_rd_data;
   logic           mem_rd_en;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   memory_arb #(.AW(AW), .DW(DW), .WED(WED)) dut (
      .clk(clk), .reset(reset),
      .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_wait(a_wr_wait),
      .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_wait(a_rd_wait),
      .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
      .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_wait(b_wr_wait),
      .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_wait(b_rd_wait),
      .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
   );

   // Dual-port memory: byte-enabled write, registered read, read-before-write
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      mem_rd_data = '0;
   end
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      for (int i = 0; i < WED; i++) begin
         if (mem_wr_en[i]) mem[mem_wr_addr][8*i +: 8] <= mem_wr_data[8*i +: 8];
      end
   end

   typedef struct {
      logic [3:0]  awe;  logic [13:0] awa;  logic [31:0] awd;  logic are;  logic [13:0] ara;
      logic [3:0]  bwe;  logic [13:0] bwa;  logic [31:0] bwd;  logic bre;  logic [13:0] bra;
      logic [3:0]  waits;
      logic [3:0]  mwe;  logic [13:0] mwa;
      logic        av;   logic [31:0] ad;   logic bv;          logic [31:0] bd;
   } vec_t;

   vec_t tbl [20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = 1'b0; a_rd_addr = '0;
      b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      a_wr_en = v.awe; a_wr_addr = v.awa; a_wr_data = v.awd; a_rd_en = v.are; a_rd_addr = v.ara;
      b_wr_en = v.bwe; b_wr_addr = v.bwa; b_wr_data = v.bwd; b_rd_en = v.bre; b_rd_addr = v.bra;
      #1;
      check($sformatf("r%0d waits", idx), {a_wr_wait, b_wr_wait, a_rd_wait, b_rd_wait}, v.waits);
      check($sformatf("r%0d mem_wr_en", idx), mem_wr_en, v.mwe);
      if (v.mwe != '0) check($sformatf("r%0d mem_wr_addr", idx), mem_wr_addr, v.mwa);
      check($sformatf("r%0d a_rd_valid", idx), a_rd_valid, v.av);
      check($sformatf("r%0d a_rd_data", idx), a_rd_data, v.ad);
      check($sformatf("r%0d b_rd_valid", idx), b_rd_valid, v.bv);
      check($sformatf("r%0d b_rd_data", idx), b_rd_data, v.bd);
   endtask

   task automatic check_mem_idle(input string tag);
      check({tag, " mem_wr_en"}, mem_wr_en, 0);
      check({tag, " mem_wr_addr"}, mem_wr_addr, 0);
      check({tag, " mem_wr_data"}, mem_wr_data, 0);
      check({tag, " mem_rd_en"}, mem_rd_en, 0);
      check({tag, " mem_rd_addr"}, mem_rd_addr, 0);
      check({tag, " a_rd_valid"}, a_rd_valid, 0);
      check({tag, " b_rd_valid"}, b_rd_valid, 0);
      check({tag, " a_rd_data"}, a_rd_data, 0);
      check({tag, " b_rd_data"}, b_rd_data, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] fwd_exp;
      //            awe  awa   awd            are ara    bwe  bwa   bwd            bre bra    waits    mwe  mwa    av ad             bv bd
      tbl[0]  = '{4'hF,14'h10,32'hDEADBEEF,1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b0,32'h0,        1'b0,32'h0};
      tbl[1]  = '{4'h0,14'h0, 32'h0,       1'b1,14'h10, 4'hF,14'h30,32'h33333333, 1'b0,14'h0,  4'b0000, 4'hF,14'h10, 1'b0,32'h0,        1'b0,32'h0};
      tbl[2]  = '{4'hF,14'h1, 32'h11111111,1'b0,14'h0,  4'hF,14'h2, 32'h22222222, 1'b0,14'h0,  4'b0100, 4'hF,14'h30, 1'b0,32'h0,        1'b0,32'h0};
      tbl[3]  = '{4'hF,14'h1, 32'h11111111,1'b0,14'h0,  4'hF,14'h2, 32'h22222222, 1'b0,14'h0,  4'b1000, 4'hF,14'h1,  1'b0,32'h0,        1'b0,32'h0};
      tbl[4]  = '{4'hF,14'h1, 32'h11111111,1'b0,14'h0,  4'hF,14'h2, 32'h22222222, 1'b0,14'h0,  4'b0100, 4'hF,14'h2,  1'b1,32'hDEADBEEF, 1'b0,32'h0};
      tbl[5]  = '{4'hF,14'h1, 32'h11111111,1'b0,14'h0,  4'hF,14'h2, 32'h22222222, 1'b0,14'h0,  4'b1000, 4'hF,14'h1,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[6]  = '{4'hF,14'h20,32'hFFFFFFFF,1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'hF,14'h2,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[7]  = '{4'h5,14'h20,32'h0,       1'b0,14'h0,  4'hF,14'h3, 32'h0BADF00D, 1'b0,14'h0,  4'b1000, 4'hF,14'h20, 1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[8]  = '{4'h5,14'h20,32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'hF,14'h3,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[9]  = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h5,14'h20, 1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[10] = '{4'h0,14'h0, 32'h0,       1'b1,14'h1,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[11] = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b1,14'h2,  4'b0000, 4'h0,14'h0,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[12] = '{4'h0,14'h0, 32'h0,       1'b1,14'h3,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b0,32'hDEADBEEF, 1'b0,32'h0};
      tbl[13] = '{4'h0,14'h0, 32'h0,       1'b1,14'h20, 4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b1,32'h11111111, 1'b0,32'h0};
      tbl[14] = '{4'h0,14'h0, 32'h0,       1'b1,14'h10, 4'h0,14'h0, 32'h0,        1'b1,14'h30, 4'b0010, 4'h0,14'h0,  1'b0,32'h11111111, 1'b1,32'h22222222};
      tbl[15] = '{4'h0,14'h0, 32'h0,       1'b1,14'h10, 4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b1,32'h0BADF00D, 1'b0,32'h22222222};
      tbl[16] = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b1,32'hFF00FF00, 1'b0,32'h22222222};
      tbl[17] = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b0,32'hFF00FF00, 1'b1,32'h33333333};
      tbl[18] = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b1,32'hDEADBEEF, 1'b0,32'h33333333};
      tbl[19] = '{4'h0,14'h0, 32'h0,       1'b0,14'h0,  4'h0,14'h0, 32'h0,        1'b0,14'h0,  4'b0000, 4'h0,14'h0,  1'b0,32'hDEADBEEF, 1'b0,32'h33333333};

      reset = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      #1;
      check_mem_idle("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) run_vec(tbl[i], i);

      // Same-address write (low two bytes) and read reach the memory in one cycle
      @(negedge clk);
      drive_idle();
      a_wr_en = 4'hF; a_wr_addr = 14'h40; a_wr_data = 32'hAAAAAAAA;
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      a_wr_en = 4'h3; a_wr_addr = 14'h40; a_wr_data = 32'h12345678;
      b_rd_en = 1'b1; b_rd_addr = 14'h40;
      #1;
      check("coll waits", {a_wr_wait, b_wr_wait, a_rd_wait, b_rd_wait}, 4'b0000);
`ifdef MEMORY_ARB_FWD_EN
      fwd_exp = 32'hAAAA5678;
`else
      fwd_exp = 32'hAAAAAAAA;
`endif
      for (int k = 1; k <= RD_LAT; k++) begin
         @(negedge clk);
         drive_idle();
         #1;
         if (k == 1) begin
            check("coll mem_rd_en", mem_rd_en, 1);
            check("coll mem_wr_en", mem_wr_en, 4'h3);
            check("coll mem_rd_addr", mem_rd_addr, 14'h40);
            check("coll mem_wr_addr", mem_wr_addr, 14'h40);
         end
         check($sformatf("coll b_rd_valid k%0d", k), b_rd_valid, (k == RD_LAT));
         check($sformatf("coll a_rd_valid k%0d", k), a_rd_valid, 0);
      end
      check("coll b_rd_data", b_rd_data, fwd_exp);

      // Reset one cycle after a read grant; pointers were left on B
      @(negedge clk);
      a_wr_en = 4'hF; a_wr_addr = 14'h50; a_wr_data = 32'h55555555;
      a_rd_en = 1'b1; a_rd_addr = 14'h10;
      @(negedge clk);
      reset = 1'b1;
      a_rd_en = 1'b0;
      a_wr_en = 4'hF; a_wr_addr = 14'h51; a_wr_data = 32'h66666666;
      #1;
      check("rst inflight mem_rd_en", mem_rd_en, 1);
      @(negedge clk);
      reset = 1'b0;
      drive_idle();
      #1;
      check_mem_idle("post-reset");
      for (int k = 0; k < RD_LAT; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("rst drop a_rd_valid k%0d", k), a_rd_valid, 0);
         check($sformatf("rst drop b_rd_valid k%0d", k), b_rd_valid, 0);
      end
      @(negedge clk);
      a_wr_en = 4'hF; a_wr_addr = 14'h60; a_wr_data = 32'h1;
      b_wr_en = 4'hF; b_wr_addr = 14'h61; b_wr_data = 32'h2;
      a_rd_en = 1'b1; a_rd_addr = 14'h10;
      b_rd_en = 1'b1; b_rd_addr = 14'h30;
      #1;
      check("rst ptr waits", {a_wr_wait, b_wr_wait, a_rd_wait, b_rd_wait}, 4'b0101);
      @(negedge clk);
      drive_idle();
      #1;
      check("rst ptr mem_wr_addr", mem_wr_addr, 14'h60);
      check("rst ptr mem_rd_addr", mem_rd_addr, 14'h10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
